// File: rtl/unidade_controle_pkg.sv
// State codes and state-code width for the memory-game control unit.
package unidade_controle_pkg;

    localparam int ESTADO_W = 5;

    localparam logic [4:0] ST_INICIAL            = 5'd0;
    localparam logic [4:0] ST_PREPARACAO         = 5'd1;
    localparam logic [4:0] ST_INICIO_EXIBICAO    = 5'd2;
    localparam logic [4:0] ST_MOSTRA_LED         = 5'd3;
    localparam logic [4:0] ST_ZERA_LED           = 5'd4;
    localparam logic [4:0] ST_APAGA_LED          = 5'd5;
    localparam logic [4:0] ST_PROXIMO_LED        = 5'd6;
    localparam logic [4:0] ST_INICIO_RODADA      = 5'd7;
    localparam logic [4:0] ST_ESPERA_JOGADA      = 5'd8;
    localparam logic [4:0] ST_REGISTRA           = 5'd9;
    localparam logic [4:0] ST_COMPARACAO         = 5'd10;
    localparam logic [4:0] ST_PROXIMA_JOGADA     = 5'd11;
    localparam logic [4:0] ST_PROXIMA_RODADA     = 5'd12;
    localparam logic [4:0] ST_FIM_ACERTOU        = 5'd13;
    localparam logic [4:0] ST_FIM_ERROU          = 5'd14;
    localparam logic [4:0] ST_FIM_TIMEOUT        = 5'd15;
    localparam logic [4:0] ST_ESPERA_NOVA_JOGADA = 5'd16;
    localparam logic [4:0] ST_REGISTRA_NOVA      = 5'd17;

    typedef enum logic [4:0] {
        INICIAL            = ST_INICIAL,
        PREPARACAO         = ST_PREPARACAO,
        INICIO_EXIBICAO    = ST_INICIO_EXIBICAO,
        MOSTRA_LED         = ST_MOSTRA_LED,
        ZERA_LED           = ST_ZERA_LED,
        APAGA_LED          = ST_APAGA_LED,
        PROXIMO_LED        = ST_PROXIMO_LED,
        INICIO_RODADA      = ST_INICIO_RODADA,
        ESPERA_JOGADA      = ST_ESPERA_JOGADA,
        REGISTRA           = ST_REGISTRA,
        COMPARACAO         = ST_COMPARACAO,
        PROXIMA_JOGADA     = ST_PROXIMA_JOGADA,
        PROXIMA_RODADA     = ST_PROXIMA_RODADA,
        FIM_ACERTOU        = ST_FIM_ACERTOU,
        FIM_ERROU          = ST_FIM_ERROU,
        FIM_TIMEOUT        = ST_FIM_TIMEOUT,
        ESPERA_NOVA_JOGADA = ST_ESPERA_NOVA_JOGADA,
        REGISTRA_NOVA      = ST_REGISTRA_NOVA
    } estado_t;

endpackage

// File: rtl/unidade_controle.sv
// Moore control FSM of the memory game: shows the sequence, checks the replay, appends a colour.
// Define UC_TIMEOUT_EN to enable the play timeout (states 8/16 -> 15 and enable_timeout).
module unidade_controle #(
    parameter int ESTADO_W = unidade_controle_pkg::ESTADO_W
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                iniciar,
    input  logic                igual,
    input  logic                fim_jogo,
    input  logic                enderecoIgualLimite,
    input  logic                jogada_feita,
    input  logic                timeout,
    input  logic                timeout_led,
    input  logic                fim_sequencia,
    input  logic                timeout_habilitado,
    output logic                zera_endereco,
    output logic                conta_endereco,
    output logic                zera_limite,
    output logic                conta_limite,
    output logic                zeraR,
    output logic                registrarR,
    output logic                zera_s_timeout,
    output logic                enable_timeout,
    output logic                registra_modo,
    output logic                zera_modo,
    output logic                conf_leds,
    output logic                registra_jogada,
    output logic                zera_s_led,
    output logic                enable_led,
    output logic                pronto,
    output logic                ganhou,
    output logic                perdeu,
    output logic                db_timeout,
    output logic [ESTADO_W-1:0] db_estado
);
    import unidade_controle_pkg::*;

    estado_t estado_q;
    estado_t estado_d;
    logic    expirou;
    logic    habilita_espera;

`ifdef UC_TIMEOUT_EN
    assign expirou         = timeout & timeout_habilitado;
    assign habilita_espera = 1'b1;
`else
    logic unused_timeout;
    assign unused_timeout  = timeout ^ timeout_habilitado;
    assign expirou         = 1'b0;
    assign habilita_espera = 1'b0;
`endif

    always_ff @(posedge clock or posedge reset) begin
        if (reset) estado_q <= INICIAL;
        else       estado_q <= estado_d;
    end

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            INICIAL:         if (iniciar) estado_d = PREPARACAO;
            PREPARACAO:      estado_d = INICIO_EXIBICAO;
            INICIO_EXIBICAO: estado_d = MOSTRA_LED;
            MOSTRA_LED:      if (timeout_led) estado_d = ZERA_LED;
            ZERA_LED:        estado_d = APAGA_LED;
            APAGA_LED: begin
                if (timeout_led) estado_d = fim_sequencia ? INICIO_RODADA : PROXIMO_LED;
            end
            PROXIMO_LED:     estado_d = MOSTRA_LED;
            INICIO_RODADA:   estado_d = ESPERA_JOGADA;
            // A press arriving together with an expiry always wins.
            ESPERA_JOGADA: begin
                if (jogada_feita) estado_d = REGISTRA;
                else if (expirou) estado_d = FIM_TIMEOUT;
            end
            REGISTRA:        estado_d = COMPARACAO;
            COMPARACAO: begin
                if (!igual)                          estado_d = FIM_ERROU;
                else if (enderecoIgualLimite && fim_jogo) estado_d = FIM_ACERTOU;
                else if (enderecoIgualLimite)        estado_d = PROXIMA_RODADA;
                else                                 estado_d = PROXIMA_JOGADA;
            end
            PROXIMA_JOGADA:  estado_d = ESPERA_JOGADA;
            PROXIMA_RODADA:  estado_d = ESPERA_NOVA_JOGADA;
            ESPERA_NOVA_JOGADA: begin
                if (jogada_feita) estado_d = REGISTRA_NOVA;
                else if (expirou) estado_d = FIM_TIMEOUT;
            end
            REGISTRA_NOVA:   estado_d = INICIO_EXIBICAO;
            FIM_ACERTOU,
            FIM_ERROU,
            FIM_TIMEOUT:     if (iniciar) estado_d = PREPARACAO;
            default:         estado_d = INICIAL;
        endcase
    end

    always_comb begin
        zera_endereco   = 1'b0;
        conta_endereco  = 1'b0;
        zera_limite     = 1'b0;
        conta_limite    = 1'b0;
        zeraR           = 1'b0;
        registrarR      = 1'b0;
        zera_s_timeout  = 1'b0;
        enable_timeout  = 1'b0;
        registra_modo   = 1'b0;
        zera_modo       = 1'b0;
        conf_leds       = 1'b0;
        registra_jogada = 1'b0;
        zera_s_led      = 1'b0;
        enable_led      = 1'b0;
        pronto          = 1'b0;
        ganhou          = 1'b0;
        perdeu          = 1'b0;
        db_timeout      = 1'b0;
        case (estado_q)
            INICIAL:         zera_modo = 1'b1;
            PREPARACAO: begin
                zera_endereco  = 1'b1;
                zera_limite    = 1'b1;
                zeraR          = 1'b1;
                registra_modo  = 1'b1;
                zera_s_timeout = 1'b1;
                zera_s_led     = 1'b1;
            end
            INICIO_EXIBICAO: begin
                zera_endereco = 1'b1;
                zera_s_led    = 1'b1;
            end
            MOSTRA_LED: begin
                conf_leds  = 1'b1;
                enable_led = 1'b1;
            end
            ZERA_LED:        zera_s_led = 1'b1;
            APAGA_LED:       enable_led = 1'b1;
            PROXIMO_LED: begin
                conta_endereco = 1'b1;
                zera_s_led     = 1'b1;
            end
            INICIO_RODADA: begin
                zera_endereco  = 1'b1;
                zera_s_timeout = 1'b1;
            end
            ESPERA_JOGADA:   enable_timeout = habilita_espera;
            REGISTRA: begin
                registrarR     = 1'b1;
                zera_s_timeout = 1'b1;
            end
            COMPARACAO:      ;
            PROXIMA_JOGADA:  conta_endereco = 1'b1;
            PROXIMA_RODADA: begin
                conta_limite   = 1'b1;
                conta_endereco = 1'b1;
                zera_s_timeout = 1'b1;
            end
            ESPERA_NOVA_JOGADA: enable_timeout = habilita_espera;
            REGISTRA_NOVA:   registra_jogada = 1'b1;
            FIM_ACERTOU: begin
                pronto = 1'b1;
                ganhou = 1'b1;
            end
            FIM_ERROU: begin
                pronto = 1'b1;
                perdeu = 1'b1;
            end
            FIM_TIMEOUT: begin
                pronto     = 1'b1;
                perdeu     = 1'b1;
                db_timeout = 1'b1;
            end
            default:         zera_modo = 1'b1;
        endcase
    end

    assign db_estado = ESTADO_W'(estado_q);

endmodule

// File: tb/tb_unidade_controle.sv
// Scoreboard bench for unidade_controle: expected state codes are queued as stimulus is driven.
module tb_unidade_controle;

    localparam int ESTADO_W = 5;

    // Input bundle order: {iniciar, igual, fim_jogo, eil, jogada, timeout, timeout_led, fim_seq, timeout_hab}
    localparam logic [8:0] NONE = 9'h000;
    localparam logic [8:0] INI  = 9'h100;
    localparam logic [8:0] IGU  = 9'h080;
    localparam logic [8:0] FJ   = 9'h040;
    localparam logic [8:0] EIL  = 9'h020;
    localparam logic [8:0] JOG  = 9'h010;
    localparam logic [8:0] TO   = 9'h008;
    localparam logic [8:0] TL   = 9'h004;
    localparam logic [8:0] FS   = 9'h002;
    localparam logic [8:0] TH   = 9'h001;

    // Output vector bit masks
    localparam logic [17:0] O_ZE   = 18'h20000;
    localparam logic [17:0] O_CE   = 18'h10000;
    localparam logic [17:0] O_ZL   = 18'h08000;
    localparam logic [17:0] O_CL   = 18'h04000;
    localparam logic [17:0] O_ZR   = 18'h02000;
    localparam logic [17:0] O_RR   = 18'h01000;
    localparam logic [17:0] O_ZST  = 18'h00800;
    localparam logic [17:0] O_ET   = 18'h00400;
    localparam logic [17:0] O_RM   = 18'h00200;
    localparam logic [17:0] O_ZM   = 18'h00100;
    localparam logic [17:0] O_CF   = 18'h00080;
    localparam logic [17:0] O_RJ   = 18'h00040;
    localparam logic [17:0] O_ZSL  = 18'h00020;
    localparam logic [17:0] O_EL   = 18'h00010;
    localparam logic [17:0] O_PR   = 18'h00008;
    localparam logic [17:0] O_GA   = 18'h00004;
    localparam logic [17:0] O_PE   = 18'h00002;
    localparam logic [17:0] O_DT   = 18'h00001;

`ifdef UC_TIMEOUT_EN
    localparam logic [17:0] ET_ON = O_ET;
`else
    localparam logic [17:0] ET_ON = 18'h0;
`endif

    logic clock = 1'b0;
    logic reset;
    logic iniciar, igual, fim_jogo, enderecoIgualLimite, jogada_feita;
    logic timeout, timeout_led, fim_sequencia, timeout_habilitado;
    logic zera_endereco, conta_endereco, zera_limite, conta_limite, zeraR, registrarR;
    logic zera_s_timeout, enable_timeout, registra_modo, zera_modo, conf_leds;
    logic registra_jogada, zera_s_led, enable_led, pronto, ganhou, perdeu, db_timeout;
    logic [ESTADO_W-1:0] db_estado;

    int n_checks = 0;
    int n_fail   = 0;
    int n_step   = 0;
    int exp_q[$];

    always #5 clock = ~clock;

    unidade_controle #(.ESTADO_W(ESTADO_W)) dut (
        .clock(clock), .reset(reset), .iniciar(iniciar), .igual(igual), .fim_jogo(fim_jogo),
        .enderecoIgualLimite(enderecoIgualLimite), .jogada_feita(jogada_feita),
        .timeout(timeout), .timeout_led(timeout_led), .fim_sequencia(fim_sequencia),
        .timeout_habilitado(timeout_habilitado),
        .zera_endereco(zera_endereco), .conta_endereco(conta_endereco),
        .zera_limite(zera_limite), .conta_limite(conta_limite), .zeraR(zeraR),
        .registrarR(registrarR), .zera_s_timeout(zera_s_timeout),
        .enable_timeout(enable_timeout), .registra_modo(registra_modo),
        .zera_modo(zera_modo), .conf_leds(conf_leds), .registra_jogada(registra_jogada),
        .zera_s_led(zera_s_led), .enable_led(enable_led), .pronto(pronto),
        .ganhou(ganhou), .perdeu(perdeu), .db_timeout(db_timeout), .db_estado(db_estado)
    );

    function automatic logic [17:0] exp_outs(input int s);
        case (s)
            0:  return O_ZM;
            1:  return O_ZE | O_ZL | O_ZR | O_RM | O_ZST | O_ZSL;
            2:  return O_ZE | O_ZSL;
            3:  return O_CF | O_EL;
            4:  return O_ZSL;
            5:  return O_EL;
            6:  return O_CE | O_ZSL;
            7:  return O_ZE | O_ZST;
            8:  return ET_ON;
            9:  return O_RR | O_ZST;
            10: return 18'h0;
            11: return O_CE;
            12: return O_CL | O_CE | O_ZST;
            13: return O_PR | O_GA;
            14: return O_PR | O_PE;
            15: return O_PR | O_PE | O_DT;
            16: return ET_ON;
            17: return O_RJ;
            default: return O_ZM;
        endcase
    endfunction

    function automatic logic [17:0] dut_outs();
        return {zera_endereco, conta_endereco, zera_limite, conta_limite, zeraR, registrarR,
                zera_s_timeout, enable_timeout, registra_modo, zera_modo, conf_leds,
                registra_jogada, zera_s_led, enable_led, pronto, ganhou, perdeu, db_timeout};
    endfunction

    task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_checks++;
        if (obs !== expv) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", tag, obs, expv);
        end
    endtask

    task automatic drive(input logic [8:0] ins);
        {iniciar, igual, fim_jogo, enderecoIgualLimite, jogada_feita,
         timeout, timeout_led, fim_sequencia, timeout_habilitado} = ins;
    endtask

    // Drive one cycle of inputs, queue the state expected after the edge, then compare.
    task automatic step(input logic [8:0] ins, input int exp_st);
        int e;
        drive(ins);
        exp_q.push_back(exp_st);
        @(posedge clock);
        #1;
        n_step++;
        if (exp_q.size() == 0) begin
            check_val($sformatf("queue_empty_%0d", n_step), 32'd0, 32'd1);
        end else begin
            e = exp_q.pop_front();
            check_val($sformatf("estado_%0d", n_step), 32'(db_estado), 32'(e));
            check_val($sformatf("saidas_%0d_st%0d", n_step, e), 32'(dut_outs()), 32'(exp_outs(e)));
        end
    endtask

    // From state 1 through the display phase (one colour) to state 8.
    task automatic show_one_to_8();
        step(NONE, 2);
        step(NONE, 3);
        step(TL, 4);
        step(NONE, 5);
        step(TL | FS, 7);
        step(NONE, 8);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout, expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        reset = 1'b1;
        drive(NONE);
        @(posedge clock);
        #1;
        check_val("reset_estado", 32'(db_estado), 32'd0);
        check_val("reset_saidas", 32'(dut_outs()), 32'(O_ZM));
        reset = 1'b0;

        step(NONE, 0);
        step(INI, 1);
        step(NONE, 2);
        step(NONE, 3);
        step(NONE, 3);
        step(TL, 4);
        step(NONE, 5);
        step(NONE, 5);
        step(TL | FS, 7);
        step(NONE, 8);
        step(NONE, 8);

        // Asynchronous reset while waiting for a play.
        reset = 1'b1;
        #1;
        check_val("midreset_estado", 32'(db_estado), 32'd0);
        check_val("midreset_saidas", 32'(dut_outs()), 32'(O_ZM));
        @(posedge clock);
        #1;
        check_val("midreset_hold", 32'(db_estado), 32'd0);
        reset = 1'b0;

        step(INI, 1);
        show_one_to_8();
        step(JOG, 9);
        step(NONE, 10);
        step(IGU | EIL, 12);
        step(NONE, 16);
        step(NONE, 16);
        step(JOG, 17);
        step(NONE, 2);
        step(NONE, 3);
        step(TL, 4);
        step(NONE, 5);
        step(TL, 6);
        step(NONE, 3);
        step(TL, 4);
        step(NONE, 5);
        step(TL | FS, 7);
        step(NONE, 8);
        step(JOG, 9);
        step(NONE, 10);
        step(IGU, 11);
        step(NONE, 8);

        step(TO, 8);
`ifdef UC_TIMEOUT_EN
        step(TO | TH, 15);
        step(NONE, 15);
        step(INI, 1);
        show_one_to_8();
`else
        step(TO | TH, 8);
`endif
        step(JOG | TO | TH, 9);
        step(NONE, 10);
        step(NONE, 14);
        step(NONE, 14);
        step(INI, 1);
        show_one_to_8();
        step(JOG, 9);
        step(NONE, 10);
        step(IGU | EIL | FJ, 13);
        step(NONE, 13);
        step(INI, 1);
        show_one_to_8();
        step(JOG, 9);
        step(NONE, 10);
        step(IGU | EIL, 12);
        step(NONE, 16);
`ifdef UC_TIMEOUT_EN
        step(TO | TH, 15);
`else
        step(TO | TH, 16);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/unidade_controle.md
Name: unidade_controle

Overview:
Control unit of the memory game. It drives every command input of the game datapath and sequences the game from the datapath's status flags. Each round runs in four steps: show the stored colour sequence on the RGB LED, check the player's replay against RAM, let the player append one new colour, then start the next round. It ends in a win, error or timeout state, and reports result and state to the top level.

Parameters:
ESTADO_W, 5, width of db_estado (18 states; must be >= 5)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high; forces state inicial
iniciar  in  1  start/restart request, level-sampled
igual, fim_jogo, enderecoIgualLimite, jogada_feita, timeout, timeout_led, fim_sequencia, timeout_habilitado  in  1 each  datapath status flags
zera_endereco, conta_endereco, zera_limite, conta_limite, zeraR, registrarR, zera_s_timeout, enable_timeout, registra_modo, zera_modo, conf_leds, registra_jogada, zera_s_led, enable_led  out  1 each  datapath commands
pronto  out  1  game finished
ganhou  out  1  win
perdeu  out  1  loss (error or timeout)
db_timeout  out  1  loss was caused by timeout
db_estado  out  ESTADO_W  current state code

Behaviour:
- Moore FSM. The state register is the only storage. All outputs are combinational decodes of state. Any command not listed for a state is 0.
- Reset (any time, including mid-round): state = inicial (0) immediately. All outputs 0 except zera_modo=1.
- States (code: asserted outputs; transition):
  0 inicial: zera_modo; iniciar -> 1
  1 preparacao: zera_endereco, zera_limite, zeraR, registra_modo, zera_s_timeout, zera_s_led; -> 2
  2 inicio_exibicao: zera_endereco, zera_s_led; -> 3
  3 mostra_led: conf_leds, enable_led; timeout_led -> 4
  4 zera_led: zera_s_led; -> 5
  5 apaga_led: enable_led (conf_leds=0); timeout_led & fim_sequencia -> 7; timeout_led & !fim_sequencia -> 6
  6 proximo_led: conta_endereco, zera_s_led; -> 3
  7 inicio_rodada: zera_endereco, zera_s_timeout; -> 8
  8 espera_jogada: enable_timeout; jogada_feita -> 9; else timeout & timeout_habilitado -> 15
  9 registra: registrarR, zera_s_timeout; -> 10
  10 comparacao: !igual -> 14; igual & enderecoIgualLimite & fim_jogo -> 13; igual & enderecoIgualLimite & !fim_jogo -> 12; otherwise -> 11
  11 proxima_jogada: conta_endereco; -> 8
  12 proxima_rodada: conta_limite, conta_endereco, zera_s_timeout; -> 16 (endereco and limite now both equal the new slot)
  16 espera_nova_jogada: enable_timeout; jogada_feita -> 17; else timeout & timeout_habilitado -> 15
  17 registra_nova: registra_jogada (RAM write of the held botoes at endereco); -> 2
  13 fim_acertou: pronto, ganhou; iniciar -> 1
  14 fim_errou: pronto, perdeu; iniciar -> 1
  15 fim_timeout: pronto, perdeu, db_timeout; iniciar -> 1
- Simultaneous jogada_feita and timeout in state 8 or 16: the jogada wins.
- Unused codes (18-31): go to inicial next cycle, with inicial's outputs.
- Latency: a press pulse is registered 1 cycle later (state 9) and compared 2 cycles later (state 10).
- db_estado = state code, zero-extended to ESTADO_W.

Optional Feature:
UC_TIMEOUT_EN
- Defined: timeout transitions from states 8 and 16 to state 15 are present, and enable_timeout is asserted in states 8 and 16.
- Undefined: enable_timeout is tied to 0, timeout and timeout_habilitado are ignored, and state 15 is unreachable (it still decodes if forced).

Decomposition:
- Package unidade_controle_pkg holds the 18 state-code localparams and ESTADO_W.
- No sub-module; the next-state logic and output decode live in one module.

Test Plan:
- Reset pulse mid-game (state 8) -> state 0 in the same cycle; all outputs 0 except zera_modo=1.
- iniciar=1, then timeout_led pulses with fim_sequencia=1 on the first gap -> state path 0,1,2,3,4,5,7,8; conf_leds=1 only in state 3.
- In state 8: jogada_feita, then igual=1, enderecoIgualLimite=1, fim_jogo=0 -> states 9,10,12,16. conta_limite and conta_endereco are high for 1 cycle. After a second jogada_feita -> state 17 with registra_jogada=1, then state 2.
- In state 10 with igual=0 -> state 14; pronto=1, perdeu=1, ganhou=0. iniciar=1 -> state 1.
- In state 10 with igual=1, enderecoIgualLimite=1, fim_jogo=1 -> state 13; pronto=1, ganhou=1.
- In state 8 with timeout=1 and timeout_habilitado=1 -> state 15, db_timeout=1 (macro defined). Same stimulus with timeout_habilitado=0 -> stays in 8. Macro undefined -> stays in 8 and enable_timeout=0. timeout and jogada_feita together -> state 9.
